// File: rtl/rsa_two_power_mod.sv
// Montgomery pre-stage: computes 2^(2*MOD_WIDTH) mod N by bit-serial double-and-reduce
// and hands base, msg, key and modulus to the exponentiator as one output beat.
module rsa_two_power_mod #(
    parameter int MOD_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_msg,
    input  logic [MOD_WIDTH-1:0] i_key,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [MOD_WIDTH-1:0] o_base,
    output logic [MOD_WIDTH-1:0] o_msg,
    output logic [MOD_WIDTH-1:0] o_key,
    output logic [MOD_WIDTH-1:0] o_modulus
);

    localparam int CNT_W = $clog2(2 * MOD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * MOD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        DONE
    } state_t;

    state_t               state;
    logic [MOD_WIDTH-1:0] r;
    logic [CNT_W-1:0]     cnt;
    logic [MOD_WIDTH:0]   t;
    logic [MOD_WIDTH-1:0] r_next;

    assign i_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    // Compare runs on the full MOD_WIDTH+1 bit doubled value; since r < N, one subtract suffices.
    always_comb begin
        t      = {r, 1'b0};
        r_next = t[MOD_WIDTH-1:0];
        if (o_modulus == '0) begin
            r_next = '0;
        end else if (t >= {1'b0, o_modulus}) begin
            r_next = MOD_WIDTH'(t - {1'b0, o_modulus});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            cnt       <= '0;
            o_base    <= '0;
            o_msg     <= '0;
            o_key     <= '0;
            o_modulus <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_msg     <= i_msg;
                        o_key     <= i_key;
                        o_modulus <= i_modulus;
                        r         <= (i_modulus < MOD_WIDTH'(2)) ? '0 : MOD_WIDTH'(1);
                        cnt       <= '0;
                        state     <= LOOP;
                    end
                end
                LOOP: begin
                    r   <= r_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        o_base <= r_next;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rsa_two_power_mod.md
# rsa_two_power_mod

Pre-stage for the Montgomery exponentiation core. It accepts a modulus N together with the message and key. It computes the Montgomery packing constant 2^(2·MOD_WIDTH) mod N by a bit-serial double-and-reduce loop, one step per cycle. It then presents base, msg, key and modulus as a single output beat that maps directly onto the exponentiator's input handshake.

## Interface
- MOD_WIDTH, 256: key/modulus width in bits; matches the codebase KeyType width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  input beat valid.
- i_ready  out  1  block can accept a beat.
- i_msg  in  MOD_WIDTH  message; passed through unchanged.
- i_key  in  MOD_WIDTH  exponent e; passed through unchanged.
- i_modulus  in  MOD_WIDTH  modulus N.
- o_valid  out  1  result beat valid.
- o_ready  in  1  downstream accepts beat.
- o_base  out  MOD_WIDTH  2^(2·MOD_WIDTH) mod N.
- o_msg, o_key, o_modulus  out  MOD_WIDTH each  registered copies of the accepted inputs.

## Operation
- Three states: IDLE, LOOP, DONE. The encoding is free; the default/illegal state returns to IDLE.
- i_ready = (state == IDLE). o_valid = (state == DONE). Both are pure state decodes.
- **IDLE**
  - On i_valid & i_ready: register msg, key and modulus.
  - Load accumulator r = (i_modulus < 2) ? 0 : 1 and step counter cnt = 0, then go to LOOP.
  - Input registers change only on an accepted beat.
- **LOOP**, once per cycle:
  - t = {r, 1'b0}, which is MOD_WIDTH+1 bits wide.
  - r <= (t >= {1'b0, N}) ? t − N : t[MOD_WIDTH-1:0].
  - cnt <= cnt + 1.
  - When cnt == 2·MOD_WIDTH−1 at the edge, perform the final step and go to DONE.
  - cnt width is $clog2(2·MOD_WIDTH).
- **Invariant:** r < N holds for all N ≥ 2, so one conditional subtract per step is sufficient. The compare and subtract are MOD_WIDTH+1 bits wide, with no truncation before the compare.
- **Degenerate modulus:**
  - N == 1: r starts at 0 and stays 0, so o_base = 0.
  - N == 0: r is forced to 0 every step, so o_base = 0.
  - Even N ≥ 2 is legal and gives the exact residue.
- **DONE**
  - o_base = r. The other outputs are the registered copies.
  - All outputs are held stable while o_valid & !o_ready.
  - On o_ready, go to IDLE.
- Outputs are registers. Their values outside DONE are the last computed values, except immediately after reset.

## Timing
- **Reset:** state = IDLE, i_ready = 1, o_valid = 0. o_base, o_msg, o_key, o_modulus, r and cnt are all 0.
- **Reset mid-operation:** rst in LOOP or DONE aborts at that edge. It returns to IDLE with every reset value above, and no partial result is emitted.
- **Latency:**
  - The accept edge is E0. LOOP occupies exactly 2·MOD_WIDTH edges.
  - o_valid is first high in the cycle after edge E0 + 2·MOD_WIDTH, i.e. 2·MOD_WIDTH + 1 cycles after the accept cycle. This is 513 for MOD_WIDTH = 256.
- **Throughput:** one job per 2·MOD_WIDTH + 2 cycles when o_ready is held high.
- **Ready after output:** i_ready is low in LOOP and DONE, and goes high the cycle after the o_valid & o_ready edge. There is no same-cycle output/input overlap.
- **Back-pressure:** o_ready is ignored outside DONE. i_valid is ignored outside IDLE, with no capture and no side effects.
- **No combinational paths:** no input-to-output combinational path exists, so o_valid and i_ready never depend on i_valid or o_ready in the same cycle.

## Test plan
- **Basic result and latency:** MOD_WIDTH=8, N=0xFB, msg=0x12, key=0x05 → o_base=0x19 (65536 mod 251). o_msg=0x12, o_key=0x05, o_modulus=0xFB. o_valid first high exactly 17 cycles after the accept cycle.
- **Residue set:** MOD_WIDTH=8 with N = 0x0D, 0xFF, 0x80, 0x02 → o_base = 0x03, 0x01, 0x00, 0x00 respectively.
- **Degenerate modulus:** MOD_WIDTH=8 with N=0x01 → o_base=0x00. With N=0x00 → o_base=0x00, and the handshake completes normally.
- **Back-pressure:** hold o_ready=0 for 10 cycles in DONE → o_valid stays 1, all outputs stay constant, i_ready stays 0. After o_ready=1 for one cycle, the next cycle shows i_ready=1 and o_valid=0.
- **Reset mid-operation:** assert rst at loop step 5 → the next cycle shows state IDLE, i_ready=1, o_valid=0 and all outputs 0. A following job with N=0xFB still yields 0x19.
- **Full-width run:** MOD_WIDTH=256 with random odd 256-bit N and back-to-back jobs → o_base matches a software pow(2,512,N) model. Jobs are spaced exactly 514 cycles apart with o_ready tied high.
